// File: rtl/mem_ctrl_if.sv
// Request/response handshake and byte-wide RAM bus between the initiator, mem_ctrl and the RAM.
// The slave modport is mem_ctrl's view; the master modport is the initiator/RAM side.
interface mem_ctrl_if #(
  parameter int RAM_ADDR_W = 17
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_sext;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic [RAM_ADDR_W-1:0] ram_a;
  logic [7:0]            ram_dout;
  logic                  ram_wr;
  logic [7:0]            ram_din;

  modport slave (
    input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, ram_din,
    output req_ready, resp_valid, resp_rdata, ram_a, ram_dout, ram_wr
  );

  modport master (
    output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, ram_din,
    input  req_ready, resp_valid, resp_rdata, ram_a, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Serializes single 1/2/4-byte load/store requests onto a byte-wide synchronous RAM,
// little-endian, one byte per cycle, and returns a one-cycle response pulse.
module mem_ctrl #(
  parameter int RAM_ADDR_W = 17
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e                state_q;
  logic [RAM_ADDR_W-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  sext_q;
  logic [31:0]           wdata_q;
  logic [31:0]           data_q;
  logic [2:0]            j_q;
  logic                  respValid_q;
  logic [31:0]           respRdata_q;
  logic [RAM_ADDR_W-1:0] ramA_q;
  logic [7:0]            ramDout_q;
  logic                  ramWr_q;

  logic [2:0]            numBytes;
  logic [2:0]            jNext;
  logic [RAM_ADDR_W-1:0] addrNext;
  logic [7:0]            wrByteNext;
  logic [31:0]           data_d;
  logic [31:0]           readResult;
  logic                  unusedAddrHi;

  assign unusedAddrHi = ^bus.req_addr[31:RAM_ADDR_W];

  assign numBytes   = (size_q == 2'd0) ? 3'd1 : (size_q == 2'd1) ? 3'd2 : 3'd4;
  assign jNext      = j_q + 3'd1;
  assign addrNext   = addr_q + RAM_ADDR_W'(jNext);
  assign wrByteNext = wdata_q[{jNext[1:0], 3'b000} +: 8];

  // In READ cycle j the RAM returns the byte addressed in cycle j-1.
  always_comb begin
    data_d = data_q;
    case (j_q)
      3'd1:    data_d[7:0]   = bus.ram_din;
      3'd2:    data_d[15:8]  = bus.ram_din;
      3'd3:    data_d[23:16] = bus.ram_din;
      3'd4:    data_d[31:24] = bus.ram_din;
      default: data_d        = data_q;
    endcase
  end

  always_comb begin
    readResult = data_d;
    if (size_q == 2'd0) begin
      readResult = {{24{sext_q & data_d[7]}}, data_d[7:0]};
    end else if (size_q == 2'd1) begin
      readResult = {{16{sext_q & data_d[15]}}, data_d[15:0]};
    end
  end

  // RAM strobes and the response are computed from the next state so they are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= 2'd0;
      sext_q      <= 1'b0;
      wdata_q     <= 32'd0;
      data_q      <= 32'd0;
      j_q         <= 3'd0;
      respValid_q <= 1'b0;
      respRdata_q <= 32'd0;
      ramA_q      <= '0;
      ramDout_q   <= 8'd0;
      ramWr_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          respValid_q <= 1'b0;
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr[RAM_ADDR_W-1:0];
            size_q  <= bus.req_size;
            sext_q  <= bus.req_sext;
            wdata_q <= bus.req_wdata;
            data_q  <= 32'd0;
            j_q     <= 3'd0;
            ramA_q  <= bus.req_addr[RAM_ADDR_W-1:0];
            if (bus.req_we) begin
              state_q   <= WRITE;
              ramWr_q   <= 1'b1;
              ramDout_q <= bus.req_wdata[7:0];
            end else begin
              state_q <= READ;
            end
          end
        end

        READ: begin
          data_q <= data_d;
          if (j_q == numBytes) begin
            state_q     <= RESP;
            respValid_q <= 1'b1;
            respRdata_q <= readResult;
          end else begin
            j_q <= jNext;
            if (jNext < numBytes) begin
              ramA_q <= addrNext;
            end
          end
        end

        WRITE: begin
          if (j_q == numBytes - 3'd1) begin
            state_q     <= RESP;
            ramWr_q     <= 1'b0;
            ramDout_q   <= 8'd0;
            respValid_q <= 1'b1;
            respRdata_q <= 32'd0;
          end else begin
            j_q       <= jNext;
            ramA_q    <= addrNext;
            ramDout_q <= wrByteNext;
          end
        end

        RESP: begin
          respValid_q <= 1'b0;
          state_q     <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = respValid_q;
  assign bus.resp_rdata = respRdata_q;
  assign bus.ram_a      = ramA_q;
  assign bus.ram_dout   = ramDout_q;
  assign bus.ram_wr     = ramWr_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-wide synchronous RAM model, a table of directed requests,
// and hand-written sequences for reset abort and a request held through a busy period.
module tb_mem_ctrl;
  localparam int RAM_ADDR_W = 17;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        preload;
    logic [31:0] preWord;
    logic [31:0] expRdata;
    int          expLatency;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   testsRun = 0;
  int   testsFailed = 0;

  logic [7:0]            ram [0:(1<<RAM_ADDR_W)-1];
  logic [RAM_ADDR_W-1:0] wrA [$];
  logic [7:0]            wrD [$];

  always #5 clk = ~clk;

  mem_ctrl_if #(.RAM_ADDR_W(RAM_ADDR_W)) busIf ();

  mem_ctrl #(.RAM_ADDR_W(RAM_ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  // Synchronous RAM: write on strobe, read data appears the cycle after the address.
  always @(posedge clk) begin
    if (busIf.ram_wr) ram[busIf.ram_a] <= busIf.ram_dout;
    busIf.ram_din <= ram[busIf.ram_a];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic preloadWord(input logic [31:0] addr, input logic [31:0] word);
    for (int k = 0; k < 4; k++) begin
      logic [RAM_ADDR_W-1:0] a;
      a = addr[RAM_ADDR_W-1:0] + RAM_ADDR_W'(k);
      ram[a] <= word[8*k +: 8];
    end
  endtask

  task automatic applyStimulus(input vec_t v, output int latency, output logic [31:0] rdata,
                               output bit readyLeak);
    int waitCnt;
    wrA.delete();
    wrD.delete();
    busIf.req_we    = v.we;
    busIf.req_size  = v.size;
    busIf.req_sext  = v.sext;
    busIf.req_addr  = v.addr;
    busIf.req_wdata = v.wdata;
    busIf.req_valid = 1'b1;
    waitCnt = 0;
    while (!busIf.req_ready && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    @(posedge clk); #1;
    busIf.req_valid = 1'b0;
    latency   = 1;
    readyLeak = 1'b0;
    rdata     = 32'hxxxxxxxx;
    while (!busIf.resp_valid && latency < 20) begin
      if (busIf.ram_wr) begin
        wrA.push_back(busIf.ram_a);
        wrD.push_back(busIf.ram_dout);
      end
      if (busIf.req_ready) readyLeak = 1'b1;
      @(posedge clk); #1;
      latency++;
    end
    if (busIf.resp_valid) begin
      rdata = busIf.resp_rdata;
      if (busIf.req_ready) readyLeak = 1'b1;
    end else begin
      latency = -1;
    end
  endtask

  vec_t vecs[15];

  initial begin
    int                    latency;
    int                    n;
    int                    firstWr;
    int                    respCount;
    logic [31:0]           rdata;
    bit                    readyLeak;
    logic [RAM_ADDR_W-1:0] expA;
    int                    respCyc [$];
    logic [31:0]           respDat [$];

    vecs[0]  = '{"rd_after_abort", 1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0, 1'b0, 32'h0, 32'h0000_BABE, 6};
    vecs[1]  = '{"wr_word_100",    1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 5};
    vecs[2]  = '{"rd_word_100",    1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 32'h0, 32'hDEAD_BEEF, 6};
    vecs[3]  = '{"rd_byte_sext1",  1'b0, 2'd0, 1'b1, 32'h0000_0200, 32'h0, 1'b1, 32'h0000_0080, 32'hFFFF_FF80, 3};
    vecs[4]  = '{"rd_byte_sext0",  1'b0, 2'd0, 1'b0, 32'h0000_0200, 32'h0, 1'b0, 32'h0, 32'h0000_0080, 3};
    vecs[5]  = '{"rd_half_sext1",  1'b0, 2'd1, 1'b1, 32'h0000_0300, 32'h0, 1'b1, 32'h0000_8001, 32'hFFFF_8001, 4};
    vecs[6]  = '{"rd_half_sext0",  1'b0, 2'd1, 1'b0, 32'h0000_0300, 32'h0, 1'b0, 32'h0, 32'h0000_8001, 4};
    vecs[7]  = '{"wr_word_wrap",   1'b1, 2'd2, 1'b0, 32'h0001_FFFF, 32'h1122_3344, 1'b0, 32'h0, 32'h0, 5};
    vecs[8]  = '{"rd_word_wrap",   1'b0, 2'd2, 1'b1, 32'h0001_FFFF, 32'h0, 1'b0, 32'h0, 32'h1122_3344, 6};
    vecs[9]  = '{"wr_half_400",    1'b1, 2'd1, 1'b0, 32'h0000_0400, 32'h1234_CAFE, 1'b1, 32'hA5A5_A5A5, 32'h0, 3};
    vecs[10] = '{"rd_word_400",    1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0, 1'b0, 32'h0, 32'hA5A5_CAFE, 6};
    vecs[11] = '{"wr_byte_403",    1'b1, 2'd0, 1'b0, 32'h0000_0403, 32'hFFFF_FF77, 1'b0, 32'h0, 32'h0, 2};
    vecs[12] = '{"rd_size3_sext",  1'b0, 2'd3, 1'b1, 32'h0000_0400, 32'h0, 1'b0, 32'h0, 32'h77A5_CAFE, 6};
    vecs[13] = '{"rd_byte_trunc",  1'b0, 2'd0, 1'b0, 32'hFFFE_0400, 32'h0, 1'b0, 32'h0, 32'h0000_00FE, 3};
    vecs[14] = '{"rd_half_pos",    1'b0, 2'd1, 1'b1, 32'h0000_0402, 32'h0, 1'b0, 32'h0, 32'h0000_77A5, 4};

    for (int i = 0; i < (1 << RAM_ADDR_W); i++) ram[i] <= 8'h00;
    busIf.req_valid = 1'b0;
    busIf.req_we    = 1'b0;
    busIf.req_size  = 2'd0;
    busIf.req_sext  = 1'b0;
    busIf.req_addr  = 32'h0;
    busIf.req_wdata = 32'h0;
    rst = 1'b1;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rst_req_ready",  {31'd0, busIf.req_ready},  32'd1);
    checkOutput("rst_resp_valid", {31'd0, busIf.resp_valid}, 32'd0);
    checkOutput("rst_resp_rdata", busIf.resp_rdata,          32'd0);
    checkOutput("rst_ram_a",      32'(busIf.ram_a),          32'd0);
    checkOutput("rst_ram_dout",   {24'd0, busIf.ram_dout},   32'd0);
    checkOutput("rst_ram_wr",     {31'd0, busIf.ram_wr},     32'd0);
    rst = 1'b0;

    // Word write aborted by reset after two bytes reached the RAM
    busIf.req_we    = 1'b1;
    busIf.req_size  = 2'd2;
    busIf.req_addr  = 32'h0000_0500;
    busIf.req_wdata = 32'hCAFE_BABE;
    busIf.req_valid = 1'b1;
    @(posedge clk); #1;
    busIf.req_valid = 1'b0;
    checkOutput("abort_c1_ram_a", 32'(busIf.ram_a), 32'h500);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("abort_c3_ram_wr", {31'd0, busIf.ram_wr}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_ram_wr_drop", {31'd0, busIf.ram_wr}, 32'd0);
    @(posedge clk); #1;
    checkOutput("abort_resp_valid", {31'd0, busIf.resp_valid}, 32'd0);
    rst = 1'b0;
    respCount = 0;
    for (int c = 0; c < 6; c++) begin
      if (busIf.resp_valid || !busIf.req_ready) respCount++;
      @(posedge clk); #1;
    end
    checkOutput("abort_idle_quiet", respCount, 32'd0);
    checkOutput("abort_mem_501", {24'd0, ram[17'h501]}, 32'h0000_00BA);
    checkOutput("abort_mem_502", {24'd0, ram[17'h502]}, 32'h0000_0000);

    // Directed request table
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].preload) preloadWord(vecs[i].addr, vecs[i].preWord);
      applyStimulus(vecs[i], latency, rdata, readyLeak);
      checkOutput({vecs[i].name, "_latency"}, latency, vecs[i].expLatency);
      checkOutput({vecs[i].name, "_rdata"}, rdata, vecs[i].expRdata);
      checkOutput({vecs[i].name, "_ready_low"}, {31'd0, readyLeak}, 32'd0);
      n = (vecs[i].size == 2'd0) ? 1 : (vecs[i].size == 2'd1) ? 2 : 4;
      checkOutput({vecs[i].name, "_wr_count"}, wrA.size(), vecs[i].we ? n : 0);
      if (vecs[i].we && wrA.size() == n) begin
        for (int k = 0; k < n; k++) begin
          expA = vecs[i].addr[RAM_ADDR_W-1:0] + RAM_ADDR_W'(k);
          checkOutput($sformatf("%s_ram_a%0d", vecs[i].name, k), 32'(wrA[k]), 32'(expA));
          checkOutput($sformatf("%s_dout%0d", vecs[i].name, k), {24'd0, wrD[k]},
                      {24'd0, vecs[i].wdata[8*k +: 8]});
        end
      end
    end

    // Request held valid through a read; contents change while busy
    busIf.req_we    = 1'b0;
    busIf.req_size  = 2'd2;
    busIf.req_sext  = 1'b0;
    busIf.req_addr  = 32'h0000_0100;
    busIf.req_wdata = 32'h0;
    busIf.req_valid = 1'b1;
    n = 0;
    while (!busIf.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    wrA.delete();
    wrD.delete();
    firstWr   = -1;
    readyLeak = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (busIf.resp_valid) begin
        respCyc.push_back(c);
        respDat.push_back(busIf.resp_rdata);
      end
      if (busIf.ram_wr) begin
        if (firstWr < 0) firstWr = c;
        wrA.push_back(busIf.ram_a);
        wrD.push_back(busIf.ram_dout);
      end
      if (c <= 6 && busIf.req_ready) readyLeak = 1'b1;
      if (c == 7) checkOutput("held_ready_c7", {31'd0, busIf.req_ready}, 32'd1);
      if (c == 2) begin
        busIf.req_we    = 1'b1;
        busIf.req_size  = 2'd1;
        busIf.req_addr  = 32'h0000_0600;
        busIf.req_wdata = 32'h0000_5A5A;
      end
      if (c == 4) busIf.req_wdata = 32'h0000_3C3C;
      if (c == 8) busIf.req_valid = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput("held_ready_low", {31'd0, readyLeak}, 32'd0);
    checkOutput("held_resp_count", respCyc.size(), 32'd2);
    if (respCyc.size() == 2) begin
      checkOutput("held_resp1_cycle", respCyc[0], 32'd6);
      checkOutput("held_resp1_rdata", respDat[0], 32'hDEAD_BEEF);
      checkOutput("held_resp2_cycle", respCyc[1], 32'd10);
      checkOutput("held_resp2_rdata", respDat[1], 32'h0);
    end
    checkOutput("held_first_wr", firstWr, 32'd8);
    checkOutput("held_wr_count", wrA.size(), 32'd2);
    if (wrA.size() == 2) begin
      checkOutput("held_ram_a0", 32'(wrA[0]), 32'h600);
      checkOutput("held_ram_a1", 32'(wrA[1]), 32'h601);
      checkOutput("held_dout0", {24'd0, wrD[0]}, 32'h3C);
      checkOutput("held_dout1", {24'd0, wrD[1]}, 32'h3C);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
